// File: rtl/ysyx_22050019_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, reset
// vector, FSM state encoding and the canonical NOP encoding.
package ysyx_22050019_ifu_pkg;

    localparam int          IFU_XLEN     = 64;
    localparam int          IFU_ILEN     = 32;
    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;   // addi x0, x0, 0

    // Fetch FSM encoding (2 bits)
    localparam logic [1:0] S_IDLE = 2'd0;   // one settle cycle after reset
    localparam logic [1:0] S_REQ  = 2'd1;   // request presented to imem
    localparam logic [1:0] S_WAIT = 2'd2;   // request accepted, awaiting data
    localparam logic [1:0] S_HOLD = 2'd3;   // instruction presented to IF/ID

endpackage

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit. Owns the fetch PC, keeps at most one imem request
// in flight, presents {pc, inst, valid} to IF/ID and holds it across stalls.
// Redirects from later stages retarget the PC; a response belonging to a
// request issued before the redirect is discarded exactly once.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req_valid_o/ready_i/addr_o  fetch request handshake
//   imem_rsp_valid_i/data_i          fetch response (one per accepted request)
//   redirect_valid_i/pc_i            branch/jump/trap retarget
//   if_id_stall_i                    IF/ID backpressure
//   pc_o/inst_o/commite_o            presented instruction and its valid
//   ifu_ok_o                         one-cycle pulse per captured instruction
module ysyx_22050019_ifu
    import ysyx_22050019_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          XLEN     = IFU_XLEN,
    parameter int          ILEN     = IFU_ILEN
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            if_id_stall_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] inst_o,
    output logic            commite_o,
    output logic            ifu_ok_o
);

    logic [1:0]      r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_pc_o;
    logic [ILEN-1:0] r_inst;
    logic            r_drop, w_drop_nxt;
    logic            r_commite, r_ok;

    logic w_xfer, w_accept, w_rsp, w_discard, w_capture, w_in_req, w_in_hold;

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_hold = (r_state == S_HOLD);
    assign w_xfer    = r_commite & ~if_id_stall_i;
    assign w_accept  = w_in_req & imem_req_ready_i;
    // Responses outside WAIT belong to nobody (e.g. abandoned by reset).
    assign w_rsp     = (r_state == S_WAIT) & imem_rsp_valid_i;
    assign w_discard = w_rsp & (r_drop | redirect_valid_i);
    assign w_capture = w_rsp & ~w_discard;

    // Redirect wins over sequential advance.
    always_comb begin
        w_pc_nxt = r_pc;
        if (redirect_valid_i)
            w_pc_nxt = {redirect_pc_i[XLEN-1:2], 2'b00};
        else if (w_in_hold && w_xfer)
            w_pc_nxt = r_pc + XLEN'(4);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                // A redirect cannot retract the request; its data is dropped later.
                if (redirect_valid_i) w_drop_nxt = 1'b1;
                if (w_accept) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_rsp)                 w_drop_nxt = 1'b0;
                else if (redirect_valid_i) w_drop_nxt = 1'b1;
                if (w_discard)      w_state_nxt = S_REQ;
                else if (w_capture) w_state_nxt = S_HOLD;
            end
            default: begin
                if (redirect_valid_i || w_xfer) w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_drop    <= 1'b0;
            r_pc_o    <= '0;
            r_inst    <= '0;
            r_commite <= 1'b0;
            r_ok      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_ok    <= w_capture;
            // The address tracks pc_q except while a request is pending: it must
            // stay stable until accepted even if a redirect moves pc_q meanwhile.
            if (!(w_in_req && !imem_req_ready_i))
                r_addr <= w_pc_nxt;
            if (w_capture) begin
                r_pc_o    <= r_pc;
                r_inst    <= imem_rsp_data_i;
                r_commite <= 1'b1;
            end else if (w_in_hold && (redirect_valid_i || w_xfer)) begin
                r_commite <= 1'b0;
            end
        end
    end

    assign imem_req_valid_o = w_in_req;
    assign imem_req_addr_o  = r_addr;
    assign pc_o             = r_pc_o;
    assign inst_o           = r_inst;
    assign commite_o        = r_commite;
    assign ifu_ok_o         = r_ok;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Randomized bench for ysyx_22050019_ifu. A transaction-level reference
// (fetch target, request/outstanding/held flags, stale-response marker) and
// a simple imem responder live here; every DUT output is compared each cycle.
module tb_ysyx_22050019_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        if_id_stall_i = 1'b0;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        commite_o;
    logic        ifu_ok_o;

    ysyx_22050019_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .if_id_stall_i(if_id_stall_i),
        .pc_o(pc_o), .inst_o(inst_o), .commite_o(commite_o), .ifu_ok_o(ifu_ok_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    bit          m_boot, m_req, m_out, m_hold, m_stale, m_ok;
    logic [63:0] m_pc, m_req_addr, m_pc_o;
    logic [31:0] m_inst;
    int          m_handed = 0;
    int          dut_handed = 0;

    // imem responder
    bit          mem_busy;
    int          mem_cnt;
    int          g_dly = 0;
    bit          g_spur = 0;
    logic [63:0] acc_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_req = 0; m_out = 0; m_hold = 0; m_stale = 0; m_ok = 0;
        m_pc = 64'h8000_0000; m_req_addr = 64'h8000_0000;
        mem_busy = 0; mem_cnt = 0;
    endtask

    task automatic start_req();
        m_req = 1;
        m_req_addr = m_pc;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " req_valid"}, 64'(imem_req_valid_o), 64'd0);
        chk({tag, " addr"},      imem_req_addr_o,       64'h8000_0000);
        chk({tag, " commite"},   64'(commite_o),        64'd0);
        chk({tag, " ifu_ok"},    64'(ifu_ok_o),         64'd0);
        chk({tag, " pc_o"},      pc_o,                  64'd0);
        chk({tag, " inst_o"},    64'(inst_o),           64'd0);
    endtask

    // One cycle: called at a negedge. Checks outputs, drives inputs, advances
    // the model to what the coming posedge should produce.
    task automatic step(input bit rdy, input bit rd, input logic [63:0] tgt, input bit st);
        bit o_boot, o_req, o_out, o_hold, rsp, acc, n_ok;
        logic [31:0] d;
        logic [63:0] a;
        o_boot = m_boot; o_req = m_req; o_out = m_out; o_hold = m_hold;

        chk("req_valid", 64'(imem_req_valid_o), 64'(m_req));
        if (m_req) chk("req_addr", imem_req_addr_o, m_req_addr);
        chk("commite", 64'(commite_o), 64'(m_hold));
        if (m_hold) begin
            chk("pc_o", pc_o, m_pc_o);
            chk("inst_o", 64'(inst_o), 64'(m_inst));
        end
        chk("ifu_ok", 64'(ifu_ok_o), 64'(m_ok));

        rsp = mem_busy && (mem_cnt == 0);
        if (!mem_busy && g_spur && $urandom_range(0, 7) == 0) rsp = 1;
        d = $urandom;
        imem_req_ready_i = rdy;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = d;
        redirect_valid_i = rd;
        redirect_pc_i    = tgt;
        if_id_stall_i    = st;
        acc = imem_req_valid_o && rdy;
        a   = imem_req_addr_o;
        if (commite_o && !st) dut_handed++;

        // reference update
        n_ok = 0;
        if (rd) m_pc = tgt & ~64'd3;
        if (o_boot) begin
            m_boot = 0;
            start_req();
        end
        if (o_req) begin
            if (rd) m_stale = 1;
            if (rdy) begin m_req = 0; m_out = 1; end
        end
        if (o_out && rsp) begin
            m_out = 0;
            if (m_stale || rd) begin
                m_stale = 0;
                start_req();
            end else begin
                m_hold = 1; m_pc_o = m_req_addr; m_inst = d; n_ok = 1;
            end
        end else if (o_out && rd) begin
            m_stale = 1;
        end
        if (o_hold) begin
            if (!st) m_handed++;
            if (rd || !st) begin
                if (!rd) m_pc = m_pc + 64'd4;
                m_hold = 0;
                start_req();
            end
        end
        m_ok = n_ok;

        @(posedge clk);
        if (mem_busy) begin
            if (rsp) mem_busy = 0;
            else mem_cnt--;
        end
        if (acc) begin
            mem_busy = 1;
            mem_cnt = g_dly;
            acc_q.push_back(a);
        end
        @(negedge clk);
    endtask

    function automatic bit cond_now(input int w);
        case (w)
            0: return m_req;
            1: return m_out;
            default: return m_hold;
        endcase
    endfunction

    task automatic run_until(input int w);
        int n = 0;
        while (!cond_now(w) && n < 64) begin
            step(1, 0, 64'd0, 0);
            n++;
        end
        chk("run_until reached", 64'(cond_now(w)), 64'd1);
    endtask

    task automatic run_acc();
        int sz = acc_q.size();
        int n = 0;
        while (acc_q.size() == sz && n < 64) begin
            step(1, 0, 64'd0, 0);
            n++;
        end
        chk("accept seen", 64'(acc_q.size() > sz), 64'd1);
    endtask

    function automatic logic [63:0] last_acc();
        if (acc_q.size() == 0) return 64'hDEAD;
        return acc_q[acc_q.size() - 1];
    endfunction

    initial begin
        int h0;
        model_reset();
        @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1;

        // sequential fetch, ready=1, rsp one cycle after accept
        g_dly = 0;
        repeat (12) step(1, 0, 64'd0, 0);
        chk("first addr",  acc_q[0], 64'h8000_0000);
        chk("second addr", acc_q[1], 64'h8000_0004);
        chk("third addr",  acc_q[2], 64'h8000_0008);

        // ready low for 5 cycles in REQ
        run_until(0);
        repeat (5) step(0, 0, 64'd0, 0);

        // IF/ID stall 4 cycles in HOLD
        run_until(2);
        repeat (4) step(1, 0, 64'd0, 1);
        step(1, 0, 64'd0, 0);

        // redirect during WAIT: response dropped, refetch aligned target
        g_dly = 2;
        run_until(1);
        step(1, 1, 64'h8000_0103, 0);
        run_acc();
        chk("redir wait addr", last_acc(), 64'h8000_0100);

        // redirect with transfer in HOLD: still handed over once
        g_dly = 0;
        run_until(2);
        h0 = dut_handed;
        step(1, 1, 64'h8000_0200, 0);
        chk("xfer+redir handed", 64'(dut_handed - h0), 64'd1);
        run_acc();
        chk("xfer+redir addr", last_acc(), 64'h8000_0200);

        // wrap at top of address space
        run_until(1);
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        run_acc();
        chk("top addr", last_acc(), 64'hFFFF_FFFF_FFFF_FFFC);
        run_until(2);
        step(1, 0, 64'd0, 0);
        run_acc();
        chk("wrap addr", last_acc(), 64'd0);

        // async reset in WAIT, late response ignored, restart at reset PC
        g_dly = 3;
        run_until(1);
        step(1, 0, 64'd0, 0);
        #2 rst_n = 0;
        #1 chk_reset_outs("async rst");
        imem_rsp_valid_i = 1;
        imem_req_ready_i = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst held");
        imem_rsp_valid_i = 0;
        rst_n = 1;
        model_reset();
        g_dly = 1;
        run_acc();
        chk("restart addr", last_acc(), 64'h8000_0000);

        // randomized traffic
        g_spur = 1;
        for (int i = 0; i < 2500; i++) begin
            logic [63:0] tgt;
            g_dly = $urandom_range(0, 3);
            tgt = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)}
                                              : {32'h0, 32'($urandom)};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, tgt,
                 $urandom_range(0, 9) < 3);
        end

        chk("handover count", 64'(dut_handed), 64'(m_handed));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
